// File: rtl/vdiv_lane.sv
// One 32-bit vector-lane integer divider: restoring radix-2, one quotient bit per cycle.
// Handles SEW8/16/32 operands, signed/unsigned, quotient/remainder, div-by-zero and overflow.
package vdiv_pkg;
  typedef struct packed {
    logic        vdiv_en;
    logic [31:0] vs1_data;
    logic [31:0] vs2_data;
    logic [2:0]  vsew;
    logic        vdivremainder;
    logic        vopunsigned;
    logic        stall;
    logic        flush;
  } vdiv_input_t;

  typedef struct packed {
    logic [31:0] vd_res;
    logic        vdiv_busy;
  } vdiv_output_t;

  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
endpackage

module vdiv_lane
  import vdiv_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  vdiv_input_t  vdiv_in,
  output vdiv_output_t vdiv_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [5:0] width_of(input logic [2:0] sew);
    case (sew)
      SEW8:    width_of = 6'd8;
      SEW16:   width_of = 6'd16;
      default: width_of = 6'd32;
    endcase
  endfunction

  // Keep the low n bits and sign- or zero-extend them to 32.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [5:0] n, input logic sgn);
    case (n)
      6'd8:    extend = sgn ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
      6'd16:   extend = sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] dvd_r;
  logic [31:0] dvs_r;
  logic [5:0]  n_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        sel_rem_r;
  logic        uns_r;
  logic [31:0] vd_res_r;
  logic        busy_s;

  logic [5:0]  n_s;
  logic        sgn_s;
  logic [31:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, min_s, special_s;
  logic        a_neg_s, b_neg_s, div0_s, ovf_s;

  // Start-of-operation decode of the live inputs (only consumed in IDLE).
  always_comb begin
    n_s     = width_of(vdiv_in.vsew);
    sgn_s   = !vdiv_in.vopunsigned;
    a_ext_s = extend(vdiv_in.vs2_data, n_s, sgn_s);
    b_ext_s = extend(vdiv_in.vs1_data, n_s, sgn_s);
    a_neg_s = sgn_s & a_ext_s[31];
    b_neg_s = sgn_s & b_ext_s[31];
    a_mag_s = a_neg_s ? (32'd0 - a_ext_s) : a_ext_s;
    b_mag_s = b_neg_s ? (32'd0 - b_ext_s) : b_ext_s;
    min_s   = extend(32'd1 << (n_s - 6'd1), n_s, 1'b1);
    div0_s  = (b_ext_s == 32'd0);
    ovf_s   = sgn_s && (a_ext_s == min_s) && (b_ext_s == 32'hFFFF_FFFF);
    if (div0_s) begin
      special_s = vdiv_in.vdivremainder ? a_ext_s : extend(32'hFFFF_FFFF, n_s, sgn_s);
    end else begin
      special_s = vdiv_in.vdivremainder ? 32'd0 : a_ext_s;
    end
  end

  logic [32:0] shifted_s, diff_s;
  logic        qbit_s;
  logic [31:0] rem_nx_s, dvd_nx_s, q_fin_s, r_fin_s, res_fin_s;

  // One restoring step; the dividend is left-aligned so quotient bits fill from the bottom.
  always_comb begin
    shifted_s = {rem_r, dvd_r[31]};
    diff_s    = shifted_s - {1'b0, dvs_r};
    qbit_s    = !diff_s[32];
    rem_nx_s  = qbit_s ? diff_s[31:0] : shifted_s[31:0];
    dvd_nx_s  = {dvd_r[30:0], qbit_s};
    q_fin_s   = neg_q_r ? (32'd0 - dvd_nx_s) : dvd_nx_s;
    r_fin_s   = neg_r_r ? (32'd0 - rem_nx_s) : rem_nx_s;
    res_fin_s = extend(sel_rem_r ? r_fin_s : q_fin_s, n_r, !uns_r);
  end

  // Busy depends only on state and the enable/flush controls.
  always_comb begin
    busy_s = 1'b0;
    if (!nRST || vdiv_in.flush) begin
      busy_s = 1'b0;
    end else if (state_r == DIV) begin
      busy_s = 1'b1;
    end else if (state_r == IDLE) begin
      busy_s = vdiv_in.vdiv_en;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      rem_r     <= 32'd0;
      dvd_r     <= 32'd0;
      dvs_r     <= 32'd0;
      n_r       <= 6'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
      uns_r     <= 1'b0;
      vd_res_r  <= 32'd0;
    end else if (vdiv_in.flush) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (vdiv_in.vdiv_en) begin
            n_r       <= n_s;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
            sel_rem_r <= vdiv_in.vdivremainder;
            uns_r     <= vdiv_in.vopunsigned;
            rem_r     <= 32'd0;
            dvd_r     <= a_mag_s << (6'd32 - n_s);
            dvs_r     <= b_mag_s;
            if (div0_s || ovf_s) begin
              vd_res_r <= special_s;
              cnt_r    <= 6'd0;
              state_r  <= DONE;
            end else begin
              cnt_r   <= n_s;
              state_r <= DIV;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DIV: begin
          rem_r <= rem_nx_s;
          dvd_r <= dvd_nx_s;
          cnt_r <= cnt_r - 6'd1;
          if (cnt_r == 6'd1) begin
            vd_res_r <= res_fin_s;
            state_r  <= DONE;
          end else begin
            state_r <= DIV;
          end
        end
        DONE: begin
          state_r <= vdiv_in.stall ? DONE : IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign vdiv_out.vd_res    = vd_res_r;
  assign vdiv_out.vdiv_busy = busy_s;

endmodule

// File: tb/tb_vdiv_lane.sv
// Self-checking bench for vdiv_lane: directed vector table, stall/flush/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_vdiv_lane;
  import vdiv_pkg::*;

  logic         CLK;
  logic         nRST;
  vdiv_input_t  din;
  vdiv_output_t dout;

  vdiv_lane dut (.CLK(CLK), .nRST(nRST), .vdiv_in(din), .vdiv_out(dout));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sew;
    logic        rem;
    logic        uns;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] prev_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: integer division truncating toward zero on the N-bit values.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sew, input logic rem,
                                        input logic uns, output int lat);
    int                 n;
    logic [63:0]        mask;
    logic signed [63:0] av, bv, q, r;
    n    = (sew == 3'd0) ? 8 : (sew == 3'd1) ? 16 : 32;
    mask = (64'd1 << n) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, b} & mask;
    if (!uns) begin
      if (av[n-1]) av = av - (64'sd1 <<< n);
      if (bv[n-1]) bv = bv - (64'sd1 <<< n);
    end
    lat = n + 1;
    if (bv == 0) begin
      q   = uns ? $signed(mask) : -64'sd1;
      r   = av;
      lat = 1;
    end else if (!uns && bv == -64'sd1 && av == -(64'sd1 <<< (n - 1))) begin
      q   = av;
      r   = 64'sd0;
      lat = 1;
    end else begin
      q = av / bv;
      r = av % bv;
    end
    return rem ? r[31:0] : q[31:0];
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sew,
                              input logic rem, input logic uns, input logic [31:0] exp, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sew = sew; v.rem = rem; v.uns = uns; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic scramble();
    din.vs1_data      = $urandom;
    din.vs2_data      = $urandom;
    din.vsew          = 3'($urandom_range(7, 0));
    din.vdivremainder = 1'($urandom_range(1, 0));
    din.vopunsigned   = 1'($urandom_range(1, 0));
    din.vdiv_en       = 1'b0;
    din.stall         = 1'b0;
    din.flush         = 1'b0;
  endtask

  task automatic start_op(input vec_t v);
    @(posedge CLK); #1;
    din.vdiv_en       = 1'b1;
    din.vs1_data      = v.b;
    din.vs2_data      = v.a;
    din.vsew          = v.sew;
    din.vdivremainder = v.rem;
    din.vopunsigned   = v.uns;
    din.stall         = 1'b0;
    din.flush         = 1'b0;
    @(negedge CLK);
    check("busy_cycle0", 32'(dout.vdiv_busy), 32'd1);
  endtask

  task automatic wait_done(input vec_t v);
    int cyc;
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      scramble();
      cyc++;
      @(negedge CLK);
    end while (dout.vdiv_busy && cyc < 40);
    check("latency", 32'(cyc), 32'(v.lat));
    check("result", dout.vd_res, v.exp);
    prev_res = v.exp;
  endtask

  task automatic run_op(input vec_t v);
    start_op(v);
    wait_done(v);
  endtask

  initial begin
    vec_t v;
    int   lat;

    tbl.push_back(mk(32'd200, 32'd7, 3'd0, 1'b0, 1'b1, 32'h0000_001C, 9));
    tbl.push_back(mk(32'd200, 32'd7, 3'd0, 1'b1, 1'b1, 32'h0000_0004, 9));
    tbl.push_back(mk(32'hABCD_00C8, 32'h1234_5607, 3'd0, 1'b0, 1'b1, 32'h0000_001C, 9));
    tbl.push_back(mk(32'h0000_FF9C, 32'h0000_0007, 3'd1, 1'b0, 1'b0, 32'hFFFF_FFF2, 17));
    tbl.push_back(mk(32'h0000_FF9C, 32'h0000_0007, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 17));
    tbl.push_back(mk(32'd5, 32'd0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk(32'd5, 32'd0, 3'd2, 1'b1, 1'b0, 32'h0000_0005, 1));
    tbl.push_back(mk(32'h0000_0037, 32'h0000_0000, 3'd0, 1'b0, 1'b1, 32'h0000_00FF, 1));
    tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 1'b0, 1'b0, 32'h8000_0000, 1));
    tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 1'b1, 1'b0, 32'h0000_0000, 1));
    tbl.push_back(mk(32'h0000_0080, 32'h0000_00FF, 3'd0, 1'b0, 1'b0, 32'hFFFF_FF80, 1));
    tbl.push_back(mk(32'd100, 32'd7, 3'd3, 1'b0, 1'b1, 32'd14, 33));
    tbl.push_back(mk(32'hFFFF_FFF9, 32'd2, 3'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 33));

    din = '0;
    din.vdiv_en = 1'b1;
    nRST = 1'b0;
    prev_res = 32'd0;
    #12;
    check("reset_res", dout.vd_res, 32'd0);
    check("reset_busy", 32'(dout.vdiv_busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    din.vdiv_en = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Hold in DONE under stall, then leave and restart.
    v = tbl[0];
    run_op(v);
    din.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("stall_busy", 32'(dout.vdiv_busy), 32'd0);
      check("stall_res", dout.vd_res, v.exp);
    end
    din.stall = 1'b0;
    run_op(tbl[3]);

    // Flush in cycle 10 of a SEW32 op.
    v = mk(32'd1000000, 32'd3, 3'd2, 1'b0, 1'b1, 32'd333333, 33);
    start_op(v);
    repeat (10) begin @(posedge CLK); #1; scramble(); end
    din.flush = 1'b1;
    @(negedge CLK);
    check("flush_busy", 32'(dout.vdiv_busy), 32'd0);
    check("flush_res", dout.vd_res, prev_res);
    @(posedge CLK); #1; scramble();
    @(negedge CLK);
    check("post_flush_busy", 32'(dout.vdiv_busy), 32'd0);
    repeat (35) @(posedge CLK);
    @(negedge CLK);
    check("post_flush_res", dout.vd_res, prev_res);

    // Flush together with enable in IDLE must not start.
    @(posedge CLK); #1;
    din.vdiv_en = 1'b1; din.vs1_data = 32'd3; din.vs2_data = 32'd9; din.flush = 1'b1;
    @(negedge CLK);
    check("flush_en_busy", 32'(dout.vdiv_busy), 32'd0);
    @(posedge CLK); #1; scramble();
    @(negedge CLK);
    check("flush_en_nostart", 32'(dout.vdiv_busy), 32'd0);
    run_op(tbl[1]);

    // Asynchronous reset in cycle 5.
    start_op(v);
    repeat (5) begin @(posedge CLK); #1; scramble(); end
    nRST = 1'b0;
    #1;
    check("midreset_res", dout.vd_res, 32'd0);
    check("midreset_busy", 32'(dout.vdiv_busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    prev_res = 32'd0;
    run_op(tbl[4]);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      v.a   = $urandom;
      v.b   = $urandom;
      case ($urandom_range(3, 0))
        0:       v.b = 32'd0;
        1:       v.b = $urandom_range(9, 1);
        2:       v.b = 32'hFFFF_FFFF;
        default: v.b = v.b;
      endcase
      if ($urandom_range(7, 0) == 0) v.a = 32'h8000_8080;
      v.sew = 3'($urandom_range(7, 0));
      v.rem = 1'($urandom_range(1, 0));
      v.uns = 1'($urandom_range(1, 0));
      v.exp = model(v.a, v.b, v.sew, v.rem, v.uns, lat);
      v.lat = lat;
      run_op(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
